// File: rtl/mpshare_pkg.sv
// mpshare shared types and widths.
// Operand/product widths and the channel tag carried beside the multiplier.
package mpshare_pkg;

  localparam int MPCAND_W = 24;
  localparam int MPLIER_W = 16;
  localparam int MPROD_W  = 40;
  localparam int CH_W     = 3;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
  } mp_tag_t;

  function automatic logic [CH_W-1:0] next_ptr(
    input logic [CH_W-1:0] v,
    input int              n
  );
    if (int'(v) >= n - 1) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/mpshare_rr_arb.sv
// Combinational round-robin picker.
// Scans from ptr upward, modulo NCH, and returns the first eligible channel.
module rr_arb
  import mpshare_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]  elig_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [NCH-1:0]  gnt_o,
  output logic [CH_W-1:0] idx_o,
  output logic            any_o
);

  int c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = 0; k < NCH; k++) begin
      c = (int'(ptr_i) + k) % NCH;
      if (!any_o && elig_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/mpshare.sv
// Shares one pipelined signed multiplier among NCH channels.
// Round-robin issue, channel tags ride alongside the multiplier pipe.
module mpshare
  import mpshare_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int MP_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req_i,
  input  logic [NCH*MPCAND_W-1:0] mpcand_i,
  input  logic [NCH*MPLIER_W-1:0] mplier_i,
  output logic [NCH-1:0]          ack_o,
  output logic [MPCAND_W-1:0]     mpcand_o,
  output logic [MPLIER_W-1:0]     mplier_o,
  input  logic [MPROD_W-1:0]      mprod_i,
  output logic [MPROD_W-1:0]      prod_o,
  output logic                    prod_valid_o,
  output logic [CH_W-1:0]         prod_ch_o
);

  // Stage 0 sits beside the operand register; the rest cover the multiplier.
  localparam int TAG_N = MP_LATENCY + 1;

  logic [NCH-1:0]      ack_q, ack_d;
  logic [MPCAND_W-1:0] mpcand_q, mpcand_d;
  logic [MPLIER_W-1:0] mplier_q, mplier_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [MPROD_W-1:0]  prod_q, prod_d;
  logic                prod_valid_q, prod_valid_d;
  logic [CH_W-1:0]     prod_ch_q, prod_ch_d;
  mp_tag_t             tag_q [TAG_N];
  mp_tag_t             tag_d [TAG_N];

  logic [NCH-1:0]      elig;
  logic [NCH-1:0]      gnt;
  logic [CH_W-1:0]     gidx;
  logic                gany;

  // A channel in its ack cycle still shows the old request.
  assign elig = req_i & ~ack_q;

  rr_arb #(
    .NCH(NCH)
  ) u_arb (
    .elig_i(elig),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  always_comb begin
    ack_d    = gany ? gnt : '0;
    ptr_d    = gany ? next_ptr(gidx, NCH) : ptr_q;
    mpcand_d = '0;
    mplier_d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt[k]) begin
        mpcand_d = mpcand_i[k*MPCAND_W +: MPCAND_W];
        mplier_d = mplier_i[k*MPLIER_W +: MPLIER_W];
      end
    end
  end

  always_comb begin
    tag_d[0].valid = gany;
    tag_d[0].ch    = gidx;
    for (int k = 1; k < TAG_N; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_comb begin
    prod_d       = mprod_i;
    prod_valid_d = tag_q[TAG_N-1].valid;
    prod_ch_d    = tag_q[TAG_N-1].ch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q        <= '0;
      mpcand_q     <= '0;
      mplier_q     <= '0;
      ptr_q        <= '0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      prod_ch_q    <= '0;
      for (int k = 0; k < TAG_N; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ack_q        <= ack_d;
      mpcand_q     <= mpcand_d;
      mplier_q     <= mplier_d;
      ptr_q        <= ptr_d;
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
      prod_ch_q    <= prod_ch_d;
      for (int k = 0; k < TAG_N; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign ack_o        = ack_q;
  assign mpcand_o     = mpcand_q;
  assign mplier_o     = mplier_q;
  assign prod_o       = prod_q;
  assign prod_valid_o = prod_valid_q;
  assign prod_ch_o    = prod_ch_q;

endmodule

// File: tb/tb_mpshare.sv
// Bench for mpshare with a behavioural pipelined multiplier.
// Scoreboard is filled on acks and drained on prod_valid_o.
module tb_mpshare;
  import mpshare_pkg::*;

  localparam int NCH = 4;
  localparam int LAT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    req_i = '0;
  logic [NCH*24-1:0] mpcand_i = '0;
  logic [NCH*16-1:0] mplier_i = '0;
  logic [NCH-1:0]    ack_o;
  logic [23:0]       mpcand_o;
  logic [15:0]       mplier_o;
  logic [39:0]       mprod_i;
  logic [39:0]       prod_o;
  logic              prod_valid_o;
  logic [2:0]        prod_ch_o;

  mpshare #(
    .NCH(NCH),
    .MP_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .mpcand_i    (mpcand_i),
    .mplier_i    (mplier_i),
    .ack_o       (ack_o),
    .mpcand_o    (mpcand_o),
    .mplier_o    (mplier_o),
    .mprod_i     (mprod_i),
    .prod_o      (prod_o),
    .prod_valid_o(prod_valid_o),
    .prod_ch_o   (prod_ch_o)
  );

  always #5 clk = ~clk;

  logic signed [39:0] mpipe [LAT];
  initial begin
    for (int k = 0; k < LAT; k++) mpipe[k] = '0;
  end
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) mpipe[k] <= mpipe[k-1];
    mpipe[0] <= $signed(mpcand_o) * $signed(mplier_o);
  end
  assign mprod_i = mpipe[LAT-1];

  typedef struct {
    int          ch;
    logic [39:0] p;
    int          c;
  } sb_t;

  sb_t         sb [$];
  logic [39:0] prod_log [$];
  int          ch_log [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [NCH*24-1:0] lat_a;
  logic [NCH*16-1:0] lat_b;
  logic [NCH-1:0]    oneshot = '1;

  always @(posedge clk) begin
    lat_a <= mpcand_i;
    lat_b <= mplier_i;
    cyc   <= cyc + 1;
  end

  int                 g;
  logic signed [23:0] ea;
  logic signed [15:0] eb;
  sb_t                e;

  always @(negedge clk) begin
    if (!rst) begin
      if (ack_o != '0) begin
        g = 0;
        for (int i = 0; i < NCH; i++) if (ack_o[i]) g = i;
        checks++;
        if ($countones(ack_o) != 1) begin
          errors++;
          $display("FAIL ack_onehot ack=%b", ack_o);
        end
        ea = lat_a[g*24 +: 24];
        eb = lat_b[g*16 +: 16];
        checks++;
        if (mpcand_o !== ea || mplier_o !== eb) begin
          errors++;
          $display("FAIL operands ch=%0d got %h/%h want %h/%h",
                   g, mpcand_o, mplier_o, ea, eb);
        end
        e.ch = g;
        e.p  = ea * eb;
        e.c  = cyc;
        sb.push_back(e);
      end else begin
        checks++;
        if (mpcand_o !== '0 || mplier_o !== '0) begin
          errors++;
          $display("FAIL idle_operands got %h/%h want 0/0",
                   mpcand_o, mplier_o);
        end
      end
      if (prod_valid_o === 1'b1) begin
        prod_log.push_back(prod_o);
        ch_log.push_back(int'(prod_ch_o));
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_prod got %h ch=%0d want none",
                   prod_o, prod_ch_o);
        end else begin
          e = sb.pop_front();
          if (prod_o !== e.p || int'(prod_ch_o) != e.ch) begin
            errors++;
            $display("FAIL prod got %h ch=%0d want %h ch=%0d",
                     prod_o, prod_ch_o, e.p, e.ch);
          end
          checks++;
          if (cyc - e.c != LAT + 1) begin
            errors++;
            $display("FAIL latency got %0d want %0d", cyc - e.c, LAT + 1);
          end
        end
      end
    end
  end

  function automatic int oh_idx(input logic [NCH-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NCH; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic set_ops(input int ch, input logic [23:0] a,
                         input logic [15:0] b);
    mpcand_i[ch*24 +: 24] = a;
    mplier_i[ch*16 +: 16] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (ack_o[i]) begin
        if (oneshot[i]) req_i[i] = 1'b0;
        else set_ops(i, 24'($urandom), 16'($urandom));
      end
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      step();
      if (sb.size() == 0 && req_i == '0 && prod_valid_o == 1'b0) ok = 1'b1;
    end
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    step();
    checks++;
    if (ack_o !== '0 || mpcand_o !== '0 || mplier_o !== '0) begin
      errors++;
      $display("FAIL reset_issue got %b %h %h want 0 0 0",
               ack_o, mpcand_o, mplier_o);
    end
    checks++;
    if (prod_o !== '0 || prod_valid_o !== 1'b0 || prod_ch_o !== '0) begin
      errors++;
      $display("FAIL reset_result got %h %b %0d want 0 0 0",
               prod_o, prod_valid_o, prod_ch_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_all_four();
    int ord [4];
    int cy [4];
    int n;
    bit ok;
    logic [39:0] want [4];
    want[0] = 40'h20000;
    want[1] = 40'hC0000;
    want[2] = 40'h1E0000;
    want[3] = -40'sh140000;
    prod_log.delete();
    ch_log.delete();
    set_ops(0, 24'h10000, 16'd2);
    set_ops(1, 24'h30000, 16'd4);
    set_ops(2, 24'h50000, 16'd6);
    set_ops(3, -24'sh10000, 16'd20);
    oneshot = '1;
    req_i = 4'b1111;
    n = 0;
    for (int t = 0; t < 20 && n < 4; t++) begin
      step();
      if (ack_o != '0) begin
        ord[n] = oh_idx(ack_o);
        cy[n] = t;
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL all4_acks got %0d acks want 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ord[k] != k || cy[k] != cy[0] + k) begin
          errors++;
          $display("FAIL all4_order slot %0d got ch%0d t%0d want ch%0d t%0d",
                   k, ord[k], cy[k], k, cy[0] + k);
        end
      end
    end
    drain(ok);
    checks++;
    if (!ok || prod_log.size() != 4) begin
      errors++;
      $display("FAIL all4_results got %0d want 4", prod_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (prod_log[k] !== want[k] || ch_log[k] != k) begin
          errors++;
          $display("FAIL all4_prod %0d got %h ch%0d want %h ch%0d",
                   k, prod_log[k], ch_log[k], want[k], k);
        end
      end
    end
  endtask

  task automatic one_shot(input string nm, input int ch,
                          input logic [23:0] a, input logic [15:0] b,
                          input logic [39:0] want);
    int t;
    bit ok;
    set_ops(ch, a, b);
    oneshot = '1;
    req_i[ch] = 1'b1;
    t = 0;
    do begin
      step();
      t++;
    end while (ack_o == '0 && t < 10);
    checks++;
    if (ack_o !== NCH'(1 << ch)) begin
      errors++;
      $display("FAIL %s_ack got %b want %b", nm, ack_o, NCH'(1 << ch));
    end
    step();
    checks++;
    if (ack_o !== '0) begin
      errors++;
      $display("FAIL %s_ack_pulse got %b want 0", nm, ack_o);
    end
    for (int k = 0; k < LAT; k++) step();
    checks++;
    if (prod_valid_o !== 1'b1 || prod_o !== want ||
        int'(prod_ch_o) != ch) begin
      errors++;
      $display("FAIL %s_prod got %b %h ch%0d want 1 %h ch%0d",
               nm, prod_valid_o, prod_o, prod_ch_o, want, ch);
    end
    step();
    checks++;
    if (prod_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid_pulse got %b want 0", nm, prod_valid_o);
    end
    drain(ok);
  endtask

  task automatic test_single();
    one_shot("single", 0, 24'h10000, 16'd2, 40'h20000);
  endtask

  task automatic test_sign();
    one_shot("sign", 2, -24'sh20000, -16'sd30, 40'h3C0000);
  endtask

  task automatic test_fairness();
    int ord [8];
    int n;
    bit ok;
    set_ops(0, 24'h000123, 16'h0042);
    set_ops(1, 24'hFFF001, 16'h7FFF);
    oneshot = 4'b1100;
    req_i = 4'b0011;
    n = 0;
    for (int t = 0; t < 30 && n < 8; t++) begin
      step();
      if (ack_o != '0) begin
        ord[n] = oh_idx(ack_o);
        n++;
        if (n == 8) req_i = '0;
      end
    end
    req_i = '0;
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL fair_acks got %0d want 8", n);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (ord[k] != (k % 2)) begin
          errors++;
          $display("FAIL fair_order slot %0d got ch%0d want ch%0d",
                   k, ord[k], k % 2);
        end
      end
    end
    oneshot = '1;
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fair_drain got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_idle();
    int ord [4];
    int n;
    bit ok;
    req_i = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (mpcand_o !== '0 || mplier_o !== '0 || prod_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL idle got %h %h %b want 0 0 0",
                 mpcand_o, mplier_o, prod_valid_o);
      end
    end
    for (int i = 0; i < NCH; i++) set_ops(i, 24'(i * 7 + 3), 16'(-i - 1));
    oneshot = '1;
    req_i = '1;
    n = 0;
    for (int t = 0; t < 20 && n < 4; t++) begin
      step();
      if (ack_o != '0) begin
        ord[n] = oh_idx(ack_o);
        n++;
      end
    end
    checks++;
    if (n != 4 || ord[0] != 2 || ord[1] != 3 || ord[2] != 0 || ord[3] != 1)
    begin
      errors++;
      $display("FAIL idle_ptr got n%0d first ch%0d want n4 order 2,3,0,1",
               n, ord[0]);
    end
    drain(ok);
  endtask

  task automatic test_reset_mid();
    int t;
    bit ok;
    set_ops(2, 24'h012345, 16'h0101);
    oneshot = '1;
    req_i[2] = 1'b1;
    t = 0;
    do begin
      step();
      t++;
    end while (ack_o == '0 && t < 10);
    checks++;
    if (ack_o !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_ack got %b want 0100", ack_o);
    end
    step();
    step();
    rst = 1'b1;
    sb.delete();
    step();
    checks++;
    if (ack_o !== '0 || mpcand_o !== '0 || mplier_o !== '0 ||
        prod_o !== '0 || prod_valid_o !== 1'b0 || prod_ch_o !== '0) begin
      errors++;
      $display("FAIL rstmid_outs got %b %h %h %h %b %0d want all 0",
               ack_o, mpcand_o, mplier_o, prod_o, prod_valid_o, prod_ch_o);
    end
    rst = 1'b0;
    for (int k = 0; k < LAT + 4; k++) begin
      step();
      checks++;
      if (prod_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stale got %b want 0", prod_valid_o);
      end
    end
    set_ops(1, 24'h000010, 16'h0010);
    set_ops(3, 24'h000020, 16'h0020);
    req_i = 4'b1010;
    t = 0;
    do begin
      step();
      t++;
    end while (ack_o == '0 && t < 10);
    checks++;
    if (ack_o !== 4'b0010) begin
      errors++;
      $display("FAIL rstmid_next got %b want 0010", ack_o);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_drain got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_sign();
    test_fairness();
    test_idle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
